// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_MULWAIT = 4'd8,
        S_ALUWB   = 4'd9,
        S_BRANCH  = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_ORR   = 3'd3;
    localparam logic [2:0] ALU_SHIFT = 3'd4;
    localparam logic [2:0] ALU_MUL   = 3'd5;
    localparam logic [2:0] ALU_MOV   = 3'd6;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [3:0] FN_AND   = 4'b0000;
    localparam logic [3:0] FN_SUB   = 4'b0010;
    localparam logic [3:0] FN_ADD   = 4'b0100;
    localparam logic [3:0] FN_MUL   = 4'b1001;
    localparam logic [3:0] FN_CMP   = 4'b1010;
    localparam logic [3:0] FN_MOV   = 4'b1011;
    localparam logic [3:0] FN_ORR   = 4'b1100;
    localparam logic [3:0] FN_SHIFT = 4'b1101;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic       arith;
        logic       mul;
        logic [2:0] code;
    } dp_op_t;

    // Unsupported opcodes decode to all-zero: ALU code 0, no write, no flags.
    function automatic dp_op_t dp_decode(input logic [3:0] fn);
        dp_op_t d;
        d = '0;
        d.valid = 1'b1;
        d.wr    = 1'b1;
        case (fn)
            FN_ADD:   begin d.code = ALU_ADD; d.arith = 1'b1; end
            FN_SUB:   begin d.code = ALU_SUB; d.arith = 1'b1; end
            FN_CMP:   begin d.code = ALU_SUB; d.arith = 1'b1; d.wr = 1'b0; end
            FN_AND:   d.code = ALU_AND;
            FN_ORR:   d.code = ALU_ORR;
            FN_SHIFT: d.code = ALU_SHIFT;
            FN_MUL:   begin d.code = ALU_MUL; d.mul = 1'b1; end
            FN_MOV:   d.code = ALU_MOV;
            default:  d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register, flag-write qualification and ARM condition evaluation.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       latch_cond,
    input  logic       result_cycle,
    input  logic       arith,
    output logic [3:0] flags,
    output logic       cond_ex_q
);

    logic n, z, c, v;
    logic cond_ex;
    logic flag_we;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Gated by the latched decision, so an instruction's own flag update never re-gates it.
    assign flag_we = result_cycle & cond_ex_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags     <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            if (latch_cond) cond_ex_q <= cond_ex;
            if (flag_we) begin
                flags[3:2] <= alu_flags[3:2];
                if (arith) flags[1:0] <= alu_flags[1:0];
            end
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller: Moore FSM with registered outputs, gated by the latched condition.
module mc_controller
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 3,
    parameter bit MUL_WAIT_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            Cond,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    input  logic [3:0]            ALUFlags,
    input  logic                  alu_done,
    output logic                  PCWrite,
    output logic                  MemWrite,
    output logic                  RegWrite,
    output logic                  IRWrite,
    output logic                  AdrSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [3:0]            Flags,
    output logic [3:0]            dbg_state
);

    state_t state, nxt;
    dp_op_t dp;
    logic   mul_waits, result_cycle, cond_ex_q;
    logic   pc_fetch_q, pc_cond_q, mem_we_q, reg_we_q, ir_we_q, adr_q, srca_q;
    logic [1:0] res_q, srcb_q;
    logic [2:0] alu_q;

    assign dp        = dp_decode(Funct[4:1]);
    assign mul_waits = dp.mul & MUL_WAIT_EN;

    // alu_done: the multiplier raises it when its result is valid; MULWAIT exits on the first cycle it is seen.
    always_comb begin
        nxt = S_FETCH;
        case (state)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b01:   nxt = S_MEMADR;
                    2'b00:   nxt = Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   nxt = S_BRANCH;
                    default: nxt = S_FETCH;
                endcase
            end
            S_MEMADR:         nxt = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:          nxt = S_MEMWB;
            S_EXECR, S_EXECI: nxt = mul_waits ? S_MULWAIT : S_ALUWB;
            S_MULWAIT:        nxt = alu_done ? S_ALUWB : S_MULWAIT;
            default:          nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            pc_fetch_q <= 1'b1;
            pc_cond_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            reg_we_q   <= 1'b0;
            ir_we_q    <= 1'b1;
            adr_q      <= 1'b0;
            srca_q     <= 1'b1;
            res_q      <= 2'b10;
            srcb_q     <= 2'b10;
            alu_q      <= ALU_ADD;
        end else begin
            state      <= nxt;
            pc_fetch_q <= 1'b0;
            pc_cond_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            reg_we_q   <= 1'b0;
            ir_we_q    <= 1'b0;
            adr_q      <= 1'b0;
            srca_q     <= 1'b0;
            res_q      <= 2'b00;
            srcb_q     <= 2'b00;
            alu_q      <= ALU_ADD;
            case (nxt)
                S_FETCH: begin
                    pc_fetch_q <= 1'b1;
                    ir_we_q    <= 1'b1;
                    srca_q     <= 1'b1;
                    res_q      <= 2'b10;
                    srcb_q     <= 2'b10;
                end
                S_DECODE: begin
                    srca_q <= 1'b1;
                    res_q  <= 2'b10;
                    srcb_q <= 2'b10;
                end
                S_MEMADR: srcb_q <= 2'b01;
                S_MEMRD:  adr_q  <= 1'b1;
                S_MEMWB: begin
                    res_q     <= 2'b01;
                    reg_we_q  <= 1'b1;
                    pc_cond_q <= (Rd == 4'hF);
                end
                S_MEMWR: begin
                    adr_q    <= 1'b1;
                    mem_we_q <= 1'b1;
                end
                S_EXECR, S_EXECI, S_MULWAIT: begin
                    srcb_q <= Funct[5] ? 2'b01 : 2'b00;
                    alu_q  <= dp.code;
                end
                S_ALUWB: begin
                    reg_we_q  <= dp.wr;
                    pc_cond_q <= dp.wr & (Rd == 4'hF);
                end
                S_BRANCH: begin
                    srcb_q    <= 2'b01;
                    res_q     <= 2'b10;
                    pc_cond_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result_cycle = dp.valid & Funct[0] &
        ((((state == S_EXECR) || (state == S_EXECI)) & ~mul_waits) |
         ((state == S_MULWAIT) & alu_done));

    cond_unit u_cond (
        .clk          (clk),
        .rst_n        (rst_n),
        .cond         (Cond),
        .alu_flags    (ALUFlags),
        .latch_cond   (state == S_DECODE),
        .result_cycle (result_cycle),
        .arith        (dp.arith),
        .flags        (Flags),
        .cond_ex_q    (cond_ex_q)
    );

    always_comb begin
        RegSrc = 2'b00;
        ImmSrc = 2'b00;
        case (Op)
            2'b01: begin
                ImmSrc = 2'b01;
                RegSrc = Funct[0] ? 2'b00 : 2'b10;
            end
            2'b10: begin
                ImmSrc = 2'b10;
                RegSrc = 2'b01;
            end
            default: ;
        endcase
    end

    assign PCWrite    = rst_n & (pc_fetch_q | (pc_cond_q & cond_ex_q));
    assign MemWrite   = rst_n & mem_we_q & cond_ex_q;
    assign RegWrite   = rst_n & reg_we_q & cond_ex_q;
    assign IRWrite    = rst_n & ir_we_q;
    assign AdrSrc     = adr_q;
    assign ALUSrcA    = srca_q;
    assign ResultSrc  = res_q;
    assign ALUSrcB    = srcb_q;
    assign ALUControl = ALU_CTRL_W'(alu_q);
    assign dbg_state  = state;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-cycle expected output vectors from a spec-level model, queued and compared.
module tb_mc_controller;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_nw = 1'b0;
    logic [3:0] Cond = 4'hE;
    logic [1:0] Op = 2'b11;
    logic [5:0] Funct = '0;
    logic [3:0] Rd = '0;
    logic [3:0] ALUFlags = '0;
    logic       alu_done = 1'b0;

    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags, dbg_state;

    logic       nw_PCWrite, nw_MemWrite, nw_RegWrite, nw_IRWrite, nw_AdrSrc, nw_ALUSrcA;
    logic [1:0] nw_ResultSrc, nw_ALUSrcB, nw_ImmSrc, nw_RegSrc;
    logic [2:0] nw_ALUControl;
    logic [3:0] nw_Flags, nw_dbg_state;

    logic [20:0] exp_q[$];
    logic [20:0] obs;
    logic [3:0]  m_flags = 4'b0000;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .alu_done(alu_done),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .Flags(Flags),
        .dbg_state(dbg_state)
    );

    mc_controller #(.ALU_CTRL_W(3), .MUL_WAIT_EN(1'b0)) dut_nw (
        .clk(clk), .rst_n(rst_nw), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .alu_done(alu_done),
        .PCWrite(nw_PCWrite), .MemWrite(nw_MemWrite), .RegWrite(nw_RegWrite), .IRWrite(nw_IRWrite),
        .AdrSrc(nw_AdrSrc), .ALUSrcA(nw_ALUSrcA), .ResultSrc(nw_ResultSrc), .ALUSrcB(nw_ALUSrcB),
        .ImmSrc(nw_ImmSrc), .RegSrc(nw_RegSrc), .ALUControl(nw_ALUControl), .Flags(nw_Flags),
        .dbg_state(nw_dbg_state)
    );

    assign obs = {dbg_state, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                  ResultSrc, ALUSrcB, ALUControl, RegSrc, ImmSrc};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // {valid, writes_rd, arith_flags, alu_code[2:0]}
    function automatic logic [5:0] m_dp(input logic [3:0] f4);
        case (f4)
            4'b0100: return {3'b111, 3'd0};
            4'b0010: return {3'b111, 3'd1};
            4'b1010: return {3'b101, 3'd1};
            4'b0000: return {3'b110, 3'd2};
            4'b1100: return {3'b110, 3'd3};
            4'b1101: return {3'b110, 3'd4};
            4'b1001: return {3'b110, 3'd5};
            4'b1011: return {3'b110, 3'd6};
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic pass,
                                            input logic [1:0] op, input logic [5:0] fn,
                                            input logic [3:0] rd);
        logic pc, mem, rw, ir, adr, srca;
        logic [1:0] res, srcb, rsrc, isrc;
        logic [2:0] alu;
        logic [5:0] d;
        d = m_dp(fn[4:1]);
        {pc, mem, rw, ir, adr, srca} = '0;
        res = 2'b00; srcb = 2'b00; alu = 3'd0;
        rsrc = (op == 2'b01 && !fn[0]) ? 2'b10 : (op == 2'b10) ? 2'b01 : 2'b00;
        isrc = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
        if (st == S_FETCH) begin pc = 1; ir = 1; srca = 1; res = 2'b10; srcb = 2'b10; end
        else if (st == S_DECODE) begin srca = 1; res = 2'b10; srcb = 2'b10; end
        else if (st == S_MEMADR) srcb = 2'b01;
        else if (st == S_MEMRD) adr = 1;
        else if (st == S_MEMWB) begin res = 2'b01; rw = pass; pc = pass && rd == 4'hF; end
        else if (st == S_MEMWR) begin adr = 1; mem = pass; end
        else if (st == S_EXECR || st == S_EXECI || st == S_MULWAIT) begin
            srcb = fn[5] ? 2'b01 : 2'b00; alu = d[2:0];
        end
        else if (st == S_ALUWB) begin rw = pass && d[4]; pc = rw && rd == 4'hF; end
        else if (st == S_BRANCH) begin srcb = 2'b01; res = 2'b10; pc = pass; end
        return {st, pc, mem, rw, ir, adr, srca, res, srcb, alu, rsrc, isrc};
    endfunction

    // Entered and left at posedge+1 of a FETCH cycle.
    task automatic run_instr(input string tag, input logic [3:0] c, input logic [1:0] op,
                             input logic [5:0] fn, input logic [3:0] rd,
                             input logic [3:0] af, input int nwait);
        logic [3:0] sts[$];
        logic       pass;
        logic [5:0] d;
        int         k;
        pass = cond_pass(c, m_flags);
        d = m_dp(fn[4:1]);
        sts.push_back(S_FETCH);
        sts.push_back(S_DECODE);
        case (op)
            2'b01: begin
                sts.push_back(S_MEMADR);
                if (fn[0]) begin sts.push_back(S_MEMRD); sts.push_back(S_MEMWB); end
                else sts.push_back(S_MEMWR);
            end
            2'b00: begin
                sts.push_back(fn[5] ? S_EXECI : S_EXECR);
                if (fn[4:1] == 4'b1001)
                    for (int j = 0; j <= nwait; j++) sts.push_back(S_MULWAIT);
                sts.push_back(S_ALUWB);
            end
            2'b10: sts.push_back(S_BRANCH);
            default: ;
        endcase
        foreach (sts[i]) exp_q.push_back(exp_vec(sts[i], pass, op, fn, rd));
        Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
        k = 0;
        for (int i = 0; i < sts.size(); i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (sts[i] == S_MULWAIT) begin alu_done = (k == nwait); k++; end
            else alu_done = 1'b0;
            @(negedge clk);
            check_eq({tag, "/cyc"}, 32'(obs), 32'(exp_q.pop_front()));
        end
        @(posedge clk); #1;
        alu_done = 1'b0;
        if (op == 2'b00 && d[5] && fn[0] && pass) begin
            m_flags[3:2] = af[3:2];
            if (d[3]) m_flags[1:0] = af[1:0];
        end
        check_eq({tag, "/flags"}, 32'(Flags), 32'(m_flags));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst/enables", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
        check_eq("rst/flags", 32'(Flags), 32'h0);
        check_eq("rst/state", 32'(dbg_state), 32'(S_FETCH));
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_flags = 4'b0000;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] fn_tab[9];
        logic [3:0] f4;
        logic [1:0] rop;
        fn_tab = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b1101, 4'b1001, 4'b1011, 4'b0111};

        @(posedge clk); #1;
        do_reset();
        run_instr("add",    4'hE, 2'b00, 6'b001000, 4'h1, 4'b1111, 0);
        run_instr("subs",   4'hE, 2'b00, 6'b000101, 4'h2, 4'b0110, 0);
        run_instr("beq",    4'h0, 2'b10, 6'b000000, 4'h0, 4'b0000, 0);
        run_instr("bne",    4'h1, 2'b10, 6'b000000, 4'h0, 4'b0000, 0);
        run_instr("ldr",    4'hE, 2'b01, 6'b011001, 4'h4, 4'b0000, 0);
        run_instr("str",    4'hE, 2'b01, 6'b011000, 4'h4, 4'b0000, 0);
        run_instr("mul",    4'hE, 2'b00, 6'b010010, 4'h5, 4'b0000, 3);
        run_instr("cmp",    4'hE, 2'b00, 6'b010101, 4'h6, 4'b1001, 0);
        run_instr("ands",   4'hE, 2'b00, 6'b000001, 4'h7, 4'b0011, 0);
        run_instr("add_pc", 4'hE, 2'b00, 6'b001000, 4'hF, 4'b0000, 0);
        run_instr("nop",    4'hE, 2'b11, 6'b000000, 4'h0, 4'b0000, 0);
        run_instr("never",  4'hF, 2'b00, 6'b001001, 4'h1, 4'b1100, 0);
        run_instr("unsup",  4'hE, 2'b00, 6'b001111, 4'h1, 4'b1100, 0);
        run_instr("orr_i",  4'hE, 2'b00, 6'b111000, 4'h3, 4'b0000, 0);
        run_instr("ldr_pc", 4'hE, 2'b01, 6'b010001, 4'hF, 4'b0000, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            f4  = fn_tab[$urandom_range(0, 8)];
            if (rop == 2'b00)
                run_instr("rand_dp", 4'($urandom_range(0, 15)), rop,
                          {1'($urandom_range(0, 1)), f4, 1'($urandom_range(0, 1))},
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3));
            else
                run_instr("rand_op", 4'($urandom_range(0, 15)), rop,
                          6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 0);
        end

        // Reset abandoning a MUL stuck in MULWAIT.
        Cond = 4'hE; Op = 2'b00; Funct = 6'b010011; Rd = 4'h2; ALUFlags = 4'b1111; alu_done = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("mrst/in_mulwait", 32'(dbg_state), 32'(S_MULWAIT));
        rst_n = 1'b0;
        @(posedge clk); #1;
        alu_done = 1'b1;
        @(negedge clk);
        check_eq("mrst/state", 32'(dbg_state), 32'(S_FETCH));
        check_eq("mrst/enables", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
        check_eq("mrst/flags", 32'(Flags), 32'h0);
        @(posedge clk); #1;
        alu_done = 1'b0;
        rst_n = 1'b1;
        m_flags = 4'b0000;
        run_instr("post_rst", 4'hE, 2'b00, 6'b000101, 4'h1, 4'b1000, 0);
        run_instr("post_bmi", 4'h4, 2'b10, 6'b000000, 4'h0, 4'b0000, 0);

        // MUL with MUL_WAIT_EN=0 goes straight to ALUWB.
        rst_n = 1'b0;
        rst_nw = 1'b1;
        Cond = 4'hE; Op = 2'b00; Funct = 6'b010010; Rd = 4'h3; alu_done = 1'b0;
        begin
            logic [3:0] nw_st[5];
            logic       nw_rw[5];
            nw_st = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH};
            nw_rw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            for (int i = 0; i < 5; i++) begin
                if (i > 0) begin @(posedge clk); #1; end
                @(negedge clk);
                check_eq("nw/state", 32'(nw_dbg_state), 32'(nw_st[i]));
                check_eq("nw/regwrite", 32'(nw_RegWrite), 32'(nw_rw[i]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
